// File: rtl/uv_gpio_irq_apb.sv
// ---------------------------------------------------------------------------
// uv_gpio_irq_apb
// GPIO controller with an APB slave.
//  - IO_NUM pins, each with pull-up/pull-down/input-enable, output value and
//    output enable, atomic set/clear aliases for the output register.
//  - Pad inputs pass a SYNC_STAGE synchroniser and a per-pin debouncer.
//  - Per-pin level/edge interrupt detection with polarity and both-edge
//    select, sticky W1C pending bits, per-pin enable mask and a registered
//    OR of all enabled pending bits.
// Ports
//  clk, rst_n                 clock, asynchronous active-low reset
//  gpio_psel .. gpio_pwdata   APB request (pprot unused)
//  gpio_prdata/pready/pslverr APB response, all registered
//  gpio_pu/pd/ie/oe/out       pad control outputs
//  gpio_in                    asynchronous pad inputs
//  gpio_irq                   per-pin PEND & IRQ_EN (combinational)
//  gpio_irq_any               OR of gpio_irq, one cycle later
// ---------------------------------------------------------------------------
module uv_gpio_irq_apb #(
    parameter int ALEN       = 12,
    parameter int DLEN       = 32,
    parameter int MLEN       = DLEN / 8,
    parameter int IO_NUM     = 32,
    parameter int SYNC_STAGE = 2,
    parameter int DEB_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gpio_psel,
    input  logic              gpio_penable,
    input  logic [2:0]        gpio_pprot,
    input  logic [ALEN-1:0]   gpio_paddr,
    input  logic [MLEN-1:0]   gpio_pstrb,
    input  logic              gpio_pwrite,
    input  logic [DLEN-1:0]   gpio_pwdata,
    output logic [DLEN-1:0]   gpio_prdata,
    output logic              gpio_pready,
    output logic              gpio_pslverr,
    output logic [IO_NUM-1:0] gpio_pu,
    output logic [IO_NUM-1:0] gpio_pd,
    output logic [IO_NUM-1:0] gpio_ie,
    input  logic [IO_NUM-1:0] gpio_in,
    output logic [IO_NUM-1:0] gpio_oe,
    output logic [IO_NUM-1:0] gpio_out,
    output logic [IO_NUM-1:0] gpio_irq,
    output logic              gpio_irq_any
);

    localparam int AW = ALEN - 2;
    localparam logic [AW-1:0] OFF_PU   = AW'(0);
    localparam logic [AW-1:0] OFF_PD   = AW'(1);
    localparam logic [AW-1:0] OFF_IN   = AW'(2);
    localparam logic [AW-1:0] OFF_IE   = AW'(3);
    localparam logic [AW-1:0] OFF_OUT  = AW'(4);
    localparam logic [AW-1:0] OFF_OE   = AW'(5);
    localparam logic [AW-1:0] OFF_PEND = AW'(6);
    localparam logic [AW-1:0] OFF_EN   = AW'(7);
    localparam logic [AW-1:0] OFF_TYPE = AW'(8);
    localparam logic [AW-1:0] OFF_POL  = AW'(9);
    localparam logic [AW-1:0] OFF_BOTH = AW'(10);
    localparam logic [AW-1:0] OFF_SET  = AW'(11);
    localparam logic [AW-1:0] OFF_CLR  = AW'(12);
    localparam logic [AW-1:0] OFF_THR  = AW'(13);

    // Byte-masked register update.
    function automatic logic [IO_NUM-1:0] f_merge(input logic [IO_NUM-1:0] old_v,
                                                  input logic [IO_NUM-1:0] wd,
                                                  input logic [IO_NUM-1:0] mask);
        f_merge = (old_v & ~mask) | (wd & mask);
    endfunction

    // Zero-extend a pin vector to the 32-bit register view.
    function automatic logic [31:0] f_zext(input logic [IO_NUM-1:0] v);
        logic [31:0] t;
        t = 32'd0;
        t[IO_NUM-1:0] = v;
        return t;
    endfunction

    logic [IO_NUM-1:0] r_pu, r_pd, r_ie, r_out, r_oe, r_pend, r_irq_en;
    logic [IO_NUM-1:0] r_type, r_pol, r_both, r_deb, r_prev;
    logic [DEB_W-1:0]  r_deb_thr;
    logic [DEB_W-1:0]  r_cnt [IO_NUM];
    logic [IO_NUM-1:0] r_sync [SYNC_STAGE];
    logic [DLEN-1:0]   r_prdata;
    logic              r_pready, r_pslverr, r_irq_any;

    logic              w_setup, w_err, w_wr, w_thr_wr;
    logic [AW-1:0]     w_off;
    logic [31:0]       w_mask32, w_rd32;
    logic [IO_NUM-1:0] w_mask, w_wd, w_sync, w_cond, w_pend_clr;
    logic [IO_NUM-1:0] w_lvl, w_edge1, w_edge;
    logic [DEB_W-1:0]  w_thr_mask, w_thr_wd;
    logic [DLEN-1:0]   w_rdata;
    logic              w_unused;

    // A transfer is taken in its setup cycle; errors block every write side effect.
    assign w_setup  = gpio_psel & ~gpio_penable;
    assign w_off    = gpio_paddr[ALEN-1:2];
    assign w_err    = (w_off > OFF_THR) | (gpio_pwrite & (w_off == OFF_IN));
    assign w_wr     = w_setup & gpio_pwrite & ~w_err;
    assign w_mask   = w_mask32[IO_NUM-1:0];
    assign w_wd     = gpio_pwdata[IO_NUM-1:0];
    assign w_thr_mask = w_mask32[DEB_W-1:0];
    assign w_thr_wd   = gpio_pwdata[DEB_W-1:0];
    assign w_thr_wr = w_wr & (w_off == OFF_THR) & (|w_thr_mask);
    assign w_sync   = r_sync[SYNC_STAGE-1];
    assign w_pend_clr = (w_wr && (w_off == OFF_PEND)) ? (w_wd & w_mask) : {IO_NUM{1'b0}};
    assign w_unused = ^{gpio_pprot, gpio_paddr[1:0], gpio_pwdata, gpio_pstrb, w_mask32};

    // Interrupt condition per pin from the debounced value and its previous cycle.
    assign w_lvl   = r_deb ^ r_pol;
    assign w_edge1 = (r_pol & r_prev & ~r_deb) | (~r_pol & ~r_prev & r_deb);
    assign w_edge  = (r_both & (r_prev ^ r_deb)) | (~r_both & w_edge1);
    assign w_cond  = (r_type & w_edge) | (~r_type & w_lvl);

    // Expand the byte strobes covering the 32 register bits into a bit mask.
    always_comb begin
        w_mask32 = 32'd0;
        for (int b = 0; b < 4; b++) begin
            w_mask32[8*b +: 8] = {8{gpio_pstrb[b]}};
        end
    end

    // Register read multiplexer; write-only and unmapped offsets read 0.
    always_comb begin
        w_rd32 = 32'd0;
        case (w_off)
            OFF_PU:   w_rd32 = f_zext(r_pu);
            OFF_PD:   w_rd32 = f_zext(r_pd);
            OFF_IN:   w_rd32 = f_zext(r_deb);
            OFF_IE:   w_rd32 = f_zext(r_ie);
            OFF_OUT:  w_rd32 = f_zext(r_out);
            OFF_OE:   w_rd32 = f_zext(r_oe);
            OFF_PEND: w_rd32 = f_zext(r_pend);
            OFF_EN:   w_rd32 = f_zext(r_irq_en);
            OFF_TYPE: w_rd32 = f_zext(r_type);
            OFF_POL:  w_rd32 = f_zext(r_pol);
            OFF_BOTH: w_rd32 = f_zext(r_both);
            OFF_THR:  w_rd32[DEB_W-1:0] = r_deb_thr;
            default:  w_rd32 = 32'd0;
        endcase
        w_rdata = {DLEN{1'b0}};
        w_rdata[31:0] = w_rd32;
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pu      <= {IO_NUM{1'b0}};
            r_pd      <= {IO_NUM{1'b0}};
            r_ie      <= {IO_NUM{1'b0}};
            r_out     <= {IO_NUM{1'b0}};
            r_oe      <= {IO_NUM{1'b0}};
            r_irq_en  <= {IO_NUM{1'b0}};
            r_type    <= {IO_NUM{1'b0}};
            r_pol     <= {IO_NUM{1'b0}};
            r_both    <= {IO_NUM{1'b0}};
            r_deb_thr <= {DEB_W{1'b0}};
        end else if (w_wr) begin
            case (w_off)
                OFF_PU:   r_pu     <= f_merge(r_pu, w_wd, w_mask);
                OFF_PD:   r_pd     <= f_merge(r_pd, w_wd, w_mask);
                OFF_IE:   r_ie     <= f_merge(r_ie, w_wd, w_mask);
                OFF_OUT:  r_out    <= f_merge(r_out, w_wd, w_mask);
                OFF_OE:   r_oe     <= f_merge(r_oe, w_wd, w_mask);
                OFF_EN:   r_irq_en <= f_merge(r_irq_en, w_wd, w_mask);
                OFF_TYPE: r_type   <= f_merge(r_type, w_wd, w_mask);
                OFF_POL:  r_pol    <= f_merge(r_pol, w_wd, w_mask);
                OFF_BOTH: r_both   <= f_merge(r_both, w_wd, w_mask);
                OFF_SET:  r_out    <= r_out | (w_wd & w_mask);
                OFF_CLR:  r_out    <= r_out & ~(w_wd & w_mask);
                OFF_THR:  r_deb_thr <= (r_deb_thr & ~w_thr_mask) | (w_thr_wd & w_thr_mask);
                default:  r_out    <= r_out;
            endcase
        end else begin
            r_out <= r_out;
        end
    end

    // APB response: single access-phase pready, read data held between transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= {DLEN{1'b0}};
        end else if (w_setup) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= (gpio_pwrite | w_err) ? {DLEN{1'b0}} : w_rdata;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end
    end

    // Pad input synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGE; s++) begin
                r_sync[s] <= {IO_NUM{1'b0}};
            end
        end else begin
            r_sync[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGE; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Per-pin debounce: the synced value must differ for DEB_THR cycles before it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb <= {IO_NUM{1'b0}};
            for (int i = 0; i < IO_NUM; i++) begin
                r_cnt[i] <= {DEB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < IO_NUM; i++) begin
                if (!r_ie[i]) begin
                    r_deb[i] <= 1'b0;
                    r_cnt[i] <= {DEB_W{1'b0}};
                end else if (w_thr_wr) begin
                    r_cnt[i] <= {DEB_W{1'b0}};
                end else if (w_sync[i] != r_deb[i]) begin
                    if (r_cnt[i] >= r_deb_thr) begin
                        r_deb[i] <= w_sync[i];
                        r_cnt[i] <= {DEB_W{1'b0}};
                    end else begin
                        r_cnt[i] <= r_cnt[i] + {{(DEB_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    r_cnt[i] <= {DEB_W{1'b0}};
                end
            end
        end
    end

    // Sticky pending bits: a new condition beats a same-cycle W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= {IO_NUM{1'b0}};
            r_pend    <= {IO_NUM{1'b0}};
            r_irq_any <= 1'b0;
        end else begin
            r_prev    <= r_deb;
            r_pend    <= (r_pend & ~w_pend_clr) | w_cond;
            r_irq_any <= |gpio_irq;
        end
    end

    assign gpio_pu      = r_pu;
    assign gpio_pd      = r_pd;
    assign gpio_ie      = r_ie;
    assign gpio_oe      = r_oe;
    assign gpio_out     = r_out;
    assign gpio_irq     = r_pend & r_irq_en;
    assign gpio_irq_any = r_irq_any;
    assign gpio_prdata  = r_prdata;
    assign gpio_pready  = r_pready;
    assign gpio_pslverr = r_pslverr;

endmodule

// File: tb/tb_uv_gpio_irq_apb.sv
// ---------------------------------------------------------------------------
// Testbench for uv_gpio_irq_apb (default parameters: 32 pins, 2 sync stages).
// A behavioural model steps once per clock edge from the register-map rules;
// a compare process checks DUT outputs against it every cycle, and directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_uv_gpio_irq_apb;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  pprot = 3'b000;
    logic [11:0] paddr = 12'd0;
    logic [3:0]  pstrb = 4'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready, pslverr, irq_any;
    logic [31:0] pu, pd, ie, gin = 32'd0, oe, gout, irq;

    uv_gpio_irq_apb dut (
        .clk(clk), .rst_n(rst_n),
        .gpio_psel(psel), .gpio_penable(penable), .gpio_pprot(pprot),
        .gpio_paddr(paddr), .gpio_pstrb(pstrb), .gpio_pwrite(pwrite),
        .gpio_pwdata(pwdata), .gpio_prdata(prdata), .gpio_pready(pready),
        .gpio_pslverr(pslverr), .gpio_pu(pu), .gpio_pd(pd), .gpio_ie(ie),
        .gpio_in(gin), .gpio_oe(oe), .gpio_out(gout), .gpio_irq(irq),
        .gpio_irq_any(irq_any)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pu, m_pd, m_ie, m_out, m_oe, m_pend, m_en, m_type, m_pol, m_both;
    logic [31:0] m_deb, m_prev, m_prdata;
    logic [7:0]  m_thr;
    int          m_cnt [32];
    logic [31:0] m_hist [$];
    bit          m_pready, m_pslverr, m_irq_any, m_last_rd, m_valid = 1'b0;

    task automatic model_reset();
        m_pu = 0; m_pd = 0; m_ie = 0; m_out = 0; m_oe = 0; m_pend = 0; m_en = 0;
        m_type = 0; m_pol = 0; m_both = 0; m_deb = 0; m_prev = 0; m_prdata = 0;
        m_thr = 0; m_pready = 0; m_pslverr = 0; m_irq_any = 0; m_last_rd = 1;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_hist = {};
        for (int s = 0; s < SYNC; s++) m_hist.push_back(32'd0);
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0: return m_pu;   1: return m_pd;   2: return m_deb;  3: return m_ie;
            4: return m_out;  5: return m_oe;   6: return m_pend; 7: return m_en;
            8: return m_type; 9: return m_pol;  10: return m_both;
            13: return {24'd0, m_thr};
            default: return 32'd0;
        endcase
    endfunction

    initial begin : model
        logic [31:0] c, mask, wd, clr, sync;
        int off;
        bit setup, err, thr_wr;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                m_valid = 1'b1;
            end else begin
                // condition from the values held before this edge
                for (int i = 0; i < 32; i++) begin
                    if (!m_type[i])     c[i] = (m_deb[i] != m_pol[i]);
                    else if (m_both[i]) c[i] = (m_prev[i] != m_deb[i]);
                    else if (m_pol[i])  c[i] = m_prev[i] && !m_deb[i];
                    else                c[i] = !m_prev[i] && m_deb[i];
                end
                setup = psel && !penable;
                off   = int'(paddr[11:2]);
                err   = (off > 13) || (pwrite && off == 2);
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = pstrb[b] ? 8'hFF : 8'h00;
                wd     = pwdata;
                clr    = (setup && pwrite && !err && off == 6) ? (wd & mask) : 32'd0;
                thr_wr = setup && pwrite && !err && off == 13 && mask[7:0] != 8'd0;
                sync   = m_hist.pop_front();
                m_hist.push_back(gin);
                m_irq_any = |(m_pend & m_en);
                m_prev = m_deb;
                for (int i = 0; i < 32; i++) begin
                    if (!m_ie[i]) begin
                        m_deb[i] = 1'b0; m_cnt[i] = 0;
                    end else if (thr_wr) begin
                        m_cnt[i] = 0;
                    end else if (sync[i] == m_prev[i]) begin
                        m_cnt[i] = 0;
                    end else if (m_cnt[i] >= int'(m_thr)) begin
                        m_deb[i] = sync[i]; m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                m_pend = (m_pend & ~clr) | c;
                m_pready = setup;
                m_pslverr = setup && err;
                if (setup && !pwrite) begin
                    m_last_rd = 1;
                    m_prdata = err ? 32'd0 : model_read(off);
                end
                if (setup && pwrite) m_last_rd = 0;
                if (setup && pwrite && !err) begin
                    case (off)
                        0:  m_pu   = (m_pu & ~mask) | (wd & mask);
                        1:  m_pd   = (m_pd & ~mask) | (wd & mask);
                        3:  m_ie   = (m_ie & ~mask) | (wd & mask);
                        4:  m_out  = (m_out & ~mask) | (wd & mask);
                        5:  m_oe   = (m_oe & ~mask) | (wd & mask);
                        7:  m_en   = (m_en & ~mask) | (wd & mask);
                        8:  m_type = (m_type & ~mask) | (wd & mask);
                        9:  m_pol  = (m_pol & ~mask) | (wd & mask);
                        10: m_both = (m_both & ~mask) | (wd & mask);
                        11: m_out  = m_out | (wd & mask);
                        12: m_out  = m_out & ~(wd & mask);
                        13: m_thr  = (m_thr & ~mask[7:0]) | (wd[7:0] & mask[7:0]);
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("out", gout, m_out);
                check("oe", oe, m_oe);
                check("ie", ie, m_ie);
                check("pu", pu, m_pu);
                check("pd", pd, m_pd);
                check("irq", irq, m_pend & m_en);
                check("irq_any", 32'(irq_any), 32'(m_irq_any));
                check("pready", 32'(pready), 32'(m_pready));
                check("pslverr", 32'(pslverr), 32'(m_pslverr));
                if (m_last_rd) check("prdata", prdata, m_prdata);
            end
        end
    end

    // ---------------- APB driver ----------------
    logic acc_irq_any;

    task automatic apb(input bit wr, input int off, input logic [31:0] wdat,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = 12'(off * 4); pwdata = wdat; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        check("pready_access", 32'(pready), 32'd1);
        rd = prdata; err = pslverr; acc_irq_any = irq_any;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'd0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] strb);
        logic [31:0] rd; logic err;
        apb(1'b1, off, d, strb, rd, err);
        check($sformatf("wr_err_off%0d", off), 32'(err), 32'd0);
    endtask

    task automatic rd_chk(input string name, input int off, input logic [31:0] exp);
        logic [31:0] rd; logic err;
        apb(1'b0, off, 32'd0, 4'd0, rd, err);
        check(name, rd, exp);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        logic [31:0] rd;
        logic err;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out", gout, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_irq_any", 32'(irq_any), 32'd0);

        // 1: output register with strobes and atomic set/clear
        wr(5, 32'h0000_00FF, 4'b1111);
        wr(4, 32'hFFFF_FFA5, 4'b0001);
        wr(11, 32'h0000_0002, 4'b1111);
        wr(12, 32'h0000_0080, 4'b1111);
        check("t1_out", gout, 32'h0000_0027);
        check("t1_oe", oe, 32'h0000_00FF);
        wr(4, 32'h1234_5678, 4'b0000);
        check("t1_nostrb", gout, 32'h0000_0027);
        rd_chk("t1_rd_out", 4, 32'h0000_0027);

        // 2: debounce threshold 3 on pin 0, observed via its level interrupt
        wr(13, 32'h0000_0003, 4'b0001);
        wr(3, 32'h0000_0001, 4'b1111);
        wr(7, 32'h0000_0001, 4'b1111);
        @(posedge clk); #1 gin[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 gin[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 gin[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            // IN rises at edge SYNC+4 = 6, pend one edge later
            if (k == 6) check("t2_irq0_early", irq & 32'h1, 32'h0);
            if (k == 7) check("t2_irq0_on", irq & 32'h1, 32'h1);
        end
        rd_chk("t2_in", 2, 32'h0000_0001);

        // 3: pin 1 rising edge, sticky after the fall, W1C
        wr(8, 32'h0000_0002, 4'b1111);
        wr(3, 32'h0000_000F, 4'b1111);
        wr(7, 32'h0000_0002, 4'b1111);
        @(posedge clk); #1 gin[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1 gin[1] = 1'b0;
        repeat (10) @(posedge clk);
        rd_chk("t3_pend_set", 6, 32'h0000_0003);
        check("t3_irq1", irq, 32'h0000_0002);
        wr(6, 32'h0000_0002, 4'b1111);
        check("t3_irq_any_lag", 32'(acc_irq_any), 32'd1);
        check("t3_irq_any_off", 32'(irq_any), 32'd0);
        rd_chk("t3_pend_clr", 6, 32'h0000_0001);

        // 4: pin 2 level-low stays pending while the source is active
        wr(9, 32'h0000_0004, 4'b1111);
        repeat (3) @(posedge clk);
        wr(6, 32'h0000_0004, 4'b1111);
        rd_chk("t4_pend_again", 6, 32'h0000_0005);
        #1 gin[2] = 1'b1;
        repeat (12) @(posedge clk);
        wr(6, 32'h0000_0004, 4'b1111);
        rd_chk("t4_pend_gone", 6, 32'h0000_0001);

        // 5: pin 3 both-edge, edge coincides with a W1C of the same bit
        wr(8, 32'h0000_000A, 4'b1111);
        wr(10, 32'h0000_0008, 4'b1111);
        @(posedge clk); #1 gin[3] = 1'b1;
        repeat (5) @(posedge clk);
        wr(6, 32'h0000_0008, 4'b1111);
        rd_chk("t5_set_wins", 6, 32'h0000_0009);

        // 6: error responses leave state untouched
        apb(1'b0, 14, 32'd0, 4'd0, rd, err);
        check("t6_rd14_err", 32'(err), 32'd1);
        check("t6_rd14_data", rd, 32'd0);
        apb(1'b1, 2, 32'hFFFF_FFFF, 4'b1111, rd, err);
        check("t6_wr_in_err", 32'(err), 32'd1);
        apb(1'b1, 15, 32'h0000_0000, 4'b1111, rd, err);
        check("t6_wr15_err", 32'(err), 32'd1);
        check("t6_out_kept", gout, 32'h0000_0027);
        rd_chk("t6_in_kept", 2, 32'h0000_000D);

        // reset in the access phase of a read
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'(4 * 4);
        @(posedge clk); #1;
        penable = 1'b1;
        check("t6_acc_pready", 32'(pready), 32'd1);
        check("t6_acc_prdata", prdata, 32'h0000_0027);
        rst_n = 1'b0;
        #1;
        check("t6_rst_pready", 32'(pready), 32'd0);
        check("t6_rst_prdata", prdata, 32'd0);
        check("t6_rst_out", gout, 32'd0);
        check("t6_rst_oe", oe, 32'd0);
        check("t6_rst_irq", irq, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
